// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch_unit and imem.
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req_out;
  logic [XLEN-1:0] imem_addr_out;
  logic            imem_ack_in;
  logic [XLEN-1:0] imem_data_in;

  // Fetch side: issues requests, receives data.
  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ack_in,
    input  imem_data_in
  );

  // Memory side: answers requests.
  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ack_in,
    output imem_data_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over the
// imem req/ack bus, presents imm24/op to the extender and redirects on branches.
// Optional macro FETCH_TIMEOUT_EN adds a request timeout counter and a terminal
// FAULT state; when undefined REQ waits indefinitely and fault_out is tied low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 16
`endif
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         stall_in,
  input  logic         branch_taken_in,
  input  logic [31:0]  branch_imm_in,
  fetch_unit_if.master imem,
  output logic         instr_valid_out,
  output logic [31:0]  instr_out,
  output logic [23:0]  imm24_out,
  output logic [1:0]   op_out,
  output logic [31:0]  pc_out,
  output logic         fault_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 24;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ   = 2'd1;
  localparam logic [ST_W-1:0] ST_VALID = 2'd2;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [ST_W-1:0] ST_FAULT = 2'd3;
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
`endif

  logic [ST_W-1:0] state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] br_pc_c;

  // Candidate next PCs, relative to the instruction being consumed.
  assign seq_pc_c = pc_out_q + 32'd4;
  assign br_pc_c  = pc_out_q + 32'd8 + (branch_imm_in << 2);

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    fault_d  = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        req_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      ST_REQ: begin
        if (imem.imem_ack_in) begin
          instr_d  = imem.imem_data_in;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          req_d    = 1'b0;
          state_d  = ST_VALID;
`ifdef FETCH_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          req_d   = 1'b0;
          valid_d = 1'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_VALID: begin
        // Consume cycle: the only place branch inputs are sampled.
        if (!stall_in) begin
          pc_d    = branch_taken_in ? br_pc_c : seq_pc_c;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

`ifdef FETCH_TIMEOUT_EN
      ST_FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Output mapping; imm24/op are plain slices of the instruction register.
  assign imem.imem_req_out  = req_q;
  assign imem.imem_addr_out = pc_q;
  assign instr_valid_out    = valid_q;
  assign instr_out          = instr_q;
  assign imm24_out          = instr_q[IMM_W-1:0];
  assign op_out             = instr_q[27:27-OP_W+1];
  assign pc_out             = pc_out_q;
`ifdef FETCH_TIMEOUT_EN
  assign fault_out          = fault_q;
`else
  assign fault_out          = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of fetch/consume records plus
// hand-written reset-mid-fetch and long-wait sequences.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] exp_addr;
    int          ack_delay;
    logic [31:0] data;
    logic [23:0] exp_imm24;
    logic [1:0]  exp_op;
    int          stall_cyc;
    logic        br;
    logic [31:0] imm;
    logic [31:0] exp_next;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_imm;
  logic        instr_valid;
  logic [31:0] instr;
  logic [23:0] imm24;
  logic [1:0]  op;
  logic [31:0] pc_o;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[9];

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .stall_in        (stall),
    .branch_taken_in (br_taken),
    .branch_imm_in   (br_imm),
    .imem            (bus),
    .instr_valid_out (instr_valid),
    .instr_out       (instr),
    .imm24_out       (imm24),
    .op_out          (op),
    .pc_out          (pc_o),
    .fault_out       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int d, input logic [31:0] w,
                              input logic [23:0] i24, input logic [1:0] o, input int s,
                              input logic b, input logic [31:0] im, input logic [31:0] nx);
    vec_t v;
    v.exp_addr = a; v.ack_delay = d; v.data = w; v.exp_imm24 = i24; v.exp_op = o;
    v.stall_cyc = s; v.br = b; v.imm = im; v.exp_next = nx;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(32'h0000_0000, 1, 32'hEA00_0003, 24'h000003, 2'b10, 0, 1'b0, 32'h0,         32'h0000_0004);
    vecs[1] = mk(32'h0000_0004, 0, 32'h1234_5678, 24'h345678, 2'b00, 5, 1'b0, 32'h0,         32'h0000_0008);
    vecs[2] = mk(32'h0000_0008, 0, 32'h0C00_0000, 24'h000000, 2'b11, 0, 1'b1, 32'h0000_003C, 32'h0000_0100);
    vecs[3] = mk(32'h0000_0100, 2, 32'h04AB_CDEF, 24'hABCDEF, 2'b01, 1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0100);
    vecs[4] = mk(32'h0000_0100, 0, 32'hFFFF_FFFF, 24'hFFFFFF, 2'b11, 0, 1'b1, 32'h0000_0010, 32'h0000_0148);
    vecs[5] = mk(32'h0000_0148, 0, 32'h0000_0000, 24'h000000, 2'b00, 0, 1'b1, 32'hC000_0000, 32'h0000_0150);
    vecs[6] = mk(32'h0000_0150, 3, 32'hA5A5_A5A5, 24'hA5A5A5, 2'b01, 0, 1'b1, 32'hFFFF_FFA9, 32'hFFFF_FFFC);
    vecs[7] = mk(32'hFFFF_FFFC, 0, 32'h1111_1111, 24'h111111, 2'b00, 0, 1'b0, 32'h0,         32'h0000_0000);
    vecs[8] = mk(32'h0000_0000, 0, 32'h2222_2222, 24'h222222, 2'b00, 0, 1'b0, 32'h0,         32'h0000_0004);

    rst_n = 1'b0;
    stall = 1'b0;
    br_taken = 1'b0;
    br_imm = '0;
    bus.imem_ack_in = 1'b0;
    bus.imem_data_in = '0;

    repeat (2) step();
    check("rst_req", 32'(bus.imem_req_out), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc_out", pc_o, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    rst_n = 1'b1;
    step();
    check("idle_to_req", 32'(bus.imem_req_out), 32'd1);

    for (int i = 0; i < 9; i++) begin
      int n;
      n = 0;
      while (!bus.imem_req_out && n < 20) begin
        step();
        n++;
      end
      check($sformatf("v%0d_req", i), 32'(bus.imem_req_out), 32'd1);
      check($sformatf("v%0d_addr", i), bus.imem_addr_out, vecs[i].exp_addr);

      repeat (vecs[i].ack_delay) step();
      if (vecs[i].ack_delay > 0) begin
        check($sformatf("v%0d_addr_hold", i), bus.imem_addr_out, vecs[i].exp_addr);
        check($sformatf("v%0d_valid_wait", i), 32'(instr_valid), 32'd0);
      end

      bus.imem_ack_in = 1'b1;
      bus.imem_data_in = vecs[i].data;
      step();
      bus.imem_ack_in = 1'b0;
      bus.imem_data_in = 32'hDEAD_BEEF;
      check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'd1);
      check($sformatf("v%0d_instr", i), instr, vecs[i].data);
      check($sformatf("v%0d_pc_out", i), pc_o, vecs[i].exp_addr);
      check($sformatf("v%0d_imm24", i), 32'(imm24), 32'(vecs[i].exp_imm24));
      check($sformatf("v%0d_op", i), 32'(op), 32'(vecs[i].exp_op));
      check($sformatf("v%0d_req_low", i), 32'(bus.imem_req_out), 32'd0);

      // Stall with distracting branch and spurious ack: everything must hold.
      for (int s = 0; s < vecs[i].stall_cyc; s++) begin
        stall = 1'b1;
        br_taken = 1'b1;
        br_imm = 32'h0000_0100;
        bus.imem_ack_in = 1'b1;
        bus.imem_data_in = 32'hBAD0_0000 + 32'(s);
        step();
        check($sformatf("v%0d_stall%0d_valid", i, s), 32'(instr_valid), 32'd1);
        check($sformatf("v%0d_stall%0d_instr", i, s), instr, vecs[i].data);
        check($sformatf("v%0d_stall%0d_pc", i, s), pc_o, vecs[i].exp_addr);
        check($sformatf("v%0d_stall%0d_req", i, s), 32'(bus.imem_req_out), 32'd0);
      end
      stall = 1'b0;
      bus.imem_ack_in = 1'b0;

      br_taken = vecs[i].br;
      br_imm = vecs[i].imm;
      step();
      br_taken = 1'b1;
      br_imm = 32'h7777_7777;
      check($sformatf("v%0d_cons_valid", i), 32'(instr_valid), 32'd0);
      check($sformatf("v%0d_cons_req", i), 32'(bus.imem_req_out), 32'd1);
      check($sformatf("v%0d_next_addr", i), bus.imem_addr_out, vecs[i].exp_next);
    end
    br_taken = 1'b0;
    br_imm = '0;

    // Reset in the middle of a request; a late ack must be ignored.
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.imem_req_out), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_addr", bus.imem_addr_out, 32'd0);
    bus.imem_ack_in = 1'b1;
    bus.imem_data_in = 32'hCAFE_F00D;
    step();
    rst_n = 1'b1;
    step();
    bus.imem_ack_in = 1'b0;
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("late_ack_instr", instr, 32'd0);
    check("restart_req", 32'(bus.imem_req_out), 32'd1);
    check("restart_addr", bus.imem_addr_out, 32'd0);

    // Long wait with no ack.
    for (int c = 1; c <= 20; c++) begin
      step();
`ifdef FETCH_TIMEOUT_EN
      if (c == 15) begin
        check("to15_fault", 32'(fault), 32'd0);
        check("to15_req", 32'(bus.imem_req_out), 32'd1);
      end
      if (c == 16) begin
        check("to16_fault", 32'(fault), 32'd1);
        check("to16_req", 32'(bus.imem_req_out), 32'd0);
        check("to16_valid", 32'(instr_valid), 32'd0);
      end
      if (c == 20) begin
        check("to20_fault", 32'(fault), 32'd1);
        check("to20_req", 32'(bus.imem_req_out), 32'd0);
      end
`else
      if (c == 20) begin
        check("wait20_fault", 32'(fault), 32'd0);
        check("wait20_req", 32'(bus.imem_req_out), 32'd1);
        check("wait20_addr", bus.imem_addr_out, 32'd0);
      end
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
